// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared constants and decode helper for the seven-segment scanner.
//   SEG_HEX    : hex nibble -> {g,f,e,d,c,b,a} active-high segment pattern
//   SEG_BLANK  : all segments dark (active-high form)
//   seg_decode : nibble/blank -> pin-level pattern for the chosen polarity
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index 0 is the rightmost entry: 0..F.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble,
                                            input logic       blank,
                                            input logic       active_low);
    logic [6:0] s;
    s = blank ? SEG_BLANK : SEG_HEX[nibble];
    return active_low ? ~s : s;
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// sevenseg_scan_ctrl_if: display-data side and pin side of the scanner.
//   master : display-data registers (drive en/digits/dp_in/blank_lz, observe pins)
//   slave  : the scan controller (consumes data, drives an/seg/dp/frame_start)
interface sevenseg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_start;

  modport master (output en, digits, dp_in, blank_lz,
                  input  an, seg, dp, frame_start);
  modport slave  (input  en, digits, dp_in, blank_lz,
                  output an, seg, dp, frame_start);
endinterface

// File: rtl/sevenseg_lz_mask.sv
// sevenseg_lz_mask: combinational leading-zero mask.
//   digits : NUM_DIGITS hex nibbles, index 0 rightmost
//   mask   : bit k set when nibble k and every nibble above it are zero;
//            bit 0 is always clear so a zero value still shows one "0".
module sevenseg_lz_mask #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [NUM_DIGITS-1:0][3:0] digits,
  output logic [NUM_DIGITS-1:0]      mask
);
  // hi_zero[k]: nibbles k..NUM_DIGITS-1 are all zero.
  logic [NUM_DIGITS:1] hi_zero;
  // Digit 0 never blanks, so its nibble plays no part in the mask.
  logic unused_d0;

  assign hi_zero[NUM_DIGITS] = 1'b1;
  assign unused_d0           = ^digits[0];
  assign mask[0]             = 1'b0;

  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_dig
    assign hi_zero[k] = hi_zero[k+1] & (digits[k] == 4'h0);
    assign mask[k]    = hi_zero[k];
  end
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: time-multiplexed common-anode seven-segment driver.
//   clk   : system clock
//   reset : synchronous, active-low
//   bus   : slave side of sevenseg_scan_ctrl_if
//           in : en, digits, dp_in, blank_lz
//           out: an (one-hot lit in ON phase), seg {g..a}, dp, frame_start
// Every output is a flop loaded from the *next* slot/cnt, so the pins on a
// visible cycle always correspond to the slot/cnt registers of that cycle.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 16,
  parameter int GUARD       = 2,
  parameter int PRE_LOAD    = 2,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  sevenseg_scan_ctrl_if.slave   bus
);
  import sevenseg_pkg::*;

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int SW = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;

  localparam logic          OFF       = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] GUARD_C   = CW'(GUARD);
  localparam logic [CW-1:0] PRE_C     = CW'(GUARD - PRE_LOAD);

  logic [SW-1:0]                slot_q, slot_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         run_q, run_d;
  logic [NUM_DIGITS-1:0][3:0]   snap_dig_q, snap_dig_d;
  logic [NUM_DIGITS-1:0]        snap_dp_q, snap_dp_d;
  logic                         snap_lz_q, snap_lz_d;
  logic [NUM_DIGITS-1:0]        an_q, an_d;
  logic [6:0]                   seg_q, seg_d;
  logic                         dp_q, dp_d;
  logic                         fs_q, fs_d;

  logic                         cap;
  logic                         pre_ok;
  logic [NUM_DIGITS-1:0]        lz_mask;

  // Mask is taken from the post-capture snapshot so slot 0 of a new frame
  // already blanks against the freshly captured value.
  sevenseg_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz (
    .digits (snap_dig_d),
    .mask   (lz_mask)
  );

  always_comb begin
    slot_d     = slot_q;
    cnt_d      = cnt_q;
    run_d      = run_q;
    cap        = 1'b0;
    snap_dig_d = snap_dig_q;
    snap_dp_d  = snap_dp_q;
    snap_lz_d  = snap_lz_q;
    an_d       = {NUM_DIGITS{OFF}};
    seg_d      = seg_q;
    dp_d       = dp_q;
    pre_ok     = 1'b0;

    if (!bus.en) begin
      slot_d = '0;
      cnt_d  = '0;
      run_d  = 1'b0;
    end else if (!run_q) begin
      // First enabled edge: restart the frame at slot 0, cnt 0.
      slot_d = '0;
      cnt_d  = '0;
      run_d  = 1'b1;
      cap    = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
      cap    = (slot_q == SLOT_LAST);
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end

    if (cap) begin
      snap_dig_d = bus.digits;
      snap_dp_d  = bus.dp_in;
      snap_lz_d  = bus.blank_lz;
    end

    fs_d = cap;

    if (!bus.en) begin
      seg_d = {7{OFF}};
      dp_d  = OFF;
    end else begin
      // Cathodes switch only at cnt == GUARD-PRE_LOAD, inside the all-off
      // guard window, so they are stable whenever an anode is lit.
      pre_ok = (cnt_d > PRE_C) || (cnt_d == PRE_C);
      if (pre_ok) begin
        seg_d = seg_decode(snap_dig_d[slot_d], snap_lz_d & lz_mask[slot_d], OFF);
        dp_d  = snap_dp_d[slot_d] ? ~OFF : OFF;
      end
      if ((cnt_d > GUARD_C) || (cnt_d == GUARD_C))
        an_d[slot_d] = ~OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_q     <= '0;
      cnt_q      <= '0;
      run_q      <= 1'b0;
      snap_dig_q <= '0;
      snap_dp_q  <= '0;
      snap_lz_q  <= 1'b0;
      an_q       <= {NUM_DIGITS{OFF}};
      seg_q      <= {7{OFF}};
      dp_q       <= OFF;
      fs_q       <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      snap_dig_q <= snap_dig_d;
      snap_dp_q  <= snap_dp_d;
      snap_lz_q  <= snap_lz_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fs_q       <= fs_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;

endmodule
